alu_issue_queue: RTL
====================

# alu_issue_queue

Buffered issue/writeback stage wrapped around the combinational 8-bit ALU (ALU8bit). It accepts opcode/operand commands over a valid/ready handshake into a DEPTH-entry FIFO, drives the queue head onto the ALU inputs, and captures the ALU's Result/flagC/flagZ into a registered output with its own valid/ready handshake. The ALU is instantiated outside this block; this block only drives its inputs and samples its outputs.

## Interface
- DEPTH, 4, command FIFO entries; power of two, >= 2
- CNT_W, 16, width of completed-operation counter
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  command present
- in_ready  out  1  command FIFO can accept
- in_opcode  in  3  ALU opcode (000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 NAND, 110 NOR, 111 XOR)
- in_op1, in_op2  in  8  operands
- Opcode  out  3  to ALU Opcode
- Operand1, Operand2  out  8  to ALU operands
- Result  in  16  from ALU
- flagC, flagZ  in  1  from ALU
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- out_result  out  16  registered result
- out_flagC, out_flagZ  out  1  registered flags
- level  out  clog2(DEPTH)+1  FIFO occupancy
- op_count  out  CNT_W  results delivered (out_valid && out_ready), wraps

## Operation
- push = in_valid && in_ready; in_ready = !rst && (level != DEPTH); no bypass when full.
- Head entry drives Opcode/Operand1/Operand2 combinationally; when FIFO empty drive 000/0x00/0x00.
- load = (level != 0) && (!out_valid || out_ready); on load: out_result <= Result, out_flagZ <= flagZ, out_flagC <= flagC if head opcode is 000/001 else 0, out_valid <= 1, FIFO pops.
- If out_valid && out_ready && !load: out_valid <= 0.
- out_valid && !out_ready: out_result/flags held stable, no pop.
- Simultaneous push and pop: level unchanged; push into empty FIFO is not visible at head until next cycle.
- Pointers wrap modulo DEPTH; level is exact count 0..DEPTH.
- Result width: passed through unmodified (SUB borrow shows as 0xFFxx with flagC=1; NAND/NOR upper byte 0xFF).
- op_count increments on out_valid && out_ready, wraps 2^CNT_W-1 -> 0.
- Reset (any cycle, including mid-stream): pointers, level = 0; out_valid = 0; out_result = 0x0000; out_flagC = out_flagZ = 0; op_count = 0; queued and held commands dropped; in_ready = 0 while rst high.

## Timing
- Push at edge k into empty FIFO with free output: head valid after k, load at edge k+1, out_valid high after k+1 (2-cycle latency).
- Sustained throughput 1 result/cycle with out_ready held high.
- Full FIFO: in_ready low in the same cycle level reaches DEPTH; high again the cycle after a pop.
- One stall cycle on out_ready drops throughput by one; no command lost or duplicated.
- First cycle after rst deasserts: in_ready = 1, out_valid = 0, level = 0.

## Test plan
- ADD 0xFF,0x01 with out_ready=1 -> out_valid 2 cycles after push, out_result 0x0100, out_flagC 1, out_flagZ 0, op_count 1.
- Back-to-back SUB 0x03,0x05; MUL 0xFF,0xFF; AND 0x0F,0xF0 -> in order: 0xFFFE/C1/Z0, 0xFE01/C0/Z0, 0x0000/C0/Z1, one per cycle.
- out_ready=0, push 5 commands with DEPTH=4 -> 1 in output register, level 4, in_ready 0, 6th held; release out_ready -> all 5 delivered in order, then the held command.
- MUL after ADD producing carry -> out_flagC 0 for MUL regardless of ALU flagC.
- Assert rst with level 3 and out_valid 1 -> next cycle out_valid 0, out_result 0x0000, level 0, op_count 0; no stale result emitted after release.
- CNT_W=4, deliver 17 results -> op_count 1.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
// Buffered issue/writeback stage around an external combinational 8-bit ALU.
// Commands are accepted over a valid/ready handshake into a DEPTH-entry FIFO.
// The FIFO head drives the ALU inputs directly. The ALU's result and flags are
// captured into an output register with its own valid/ready handshake.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         command handshake
//   in_opcode, in_op1, in_op2 command payload (3-bit opcode, two 8-bit operands)
//   Opcode, Operand1, Operand2  head-of-queue command driven to the ALU
//   Result, flagC, flagZ      ALU outputs sampled on load
//   out_valid/out_ready       result handshake
//   out_result, out_flagC, out_flagZ  registered result
//   level                     FIFO occupancy, 0..DEPTH
//   op_count                  delivered-result counter, wraps
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [7:0]               in_op1,
  input  logic [7:0]               in_op2,
  output logic [2:0]               Opcode,
  output logic [7:0]               Operand1,
  output logic [7:0]               Operand2,
  input  logic [15:0]              Result,
  input  logic                     flagC,
  input  logic                     flagZ,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic                     out_flagC,
  output logic                     out_flagZ,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         op_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OPND_W  = 8;
  localparam int unsigned ENTRY_W = OPC_W + 2 * OPND_W;

  // Command storage: {opcode, op1, op2}
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic load;
  logic deliver;
  logic keep_carry;

  // Handshake and occupancy decode
  always_comb begin
    fifo_full  = (level == LVL_W'(DEPTH));
    fifo_empty = (level == '0);
    in_ready   = !rst && !fifo_full;
    push       = in_valid && in_ready;
    deliver    = out_valid && out_ready;
    // Output register is free when empty or being drained this cycle
    load       = !fifo_empty && (!out_valid || out_ready);
  end

  // Head of queue onto the ALU; idle pattern when empty
  always_comb begin
    head     = mem[rd_ptr];
    Opcode   = '0;
    Operand1 = '0;
    Operand2 = '0;
    if (!fifo_empty) begin
      Opcode   = head[ENTRY_W-1 -: OPC_W];
      Operand1 = head[2*OPND_W-1 -: OPND_W];
      Operand2 = head[OPND_W-1:0];
    end
  end

  // Carry is only meaningful for ADD (000) and SUB (001)
  always_comb begin
    keep_carry = (Opcode[2:1] == 2'b00);
  end

  // Command storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_opcode, in_op1, in_op2};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth gives natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, load})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Result register: capture on load, clear valid when drained with nothing behind
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flagC  <= 1'b0;
      out_flagZ  <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= Result;
      out_flagC  <= keep_carry ? flagC : 1'b0;
      out_flagZ  <= flagZ;
    end else if (deliver) begin
      out_valid  <= 1'b0;
    end
  end

  // Delivered-result counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (deliver) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
